// File: rtl/des_sbox_engine.sv
// DES S-layer (S1..S8) evaluated LANES boxes per clock; 48-bit key-mixed word in, 32-bit word out.
// Valid/ready on both sides; one word in flight, result held in DONE until the consumer takes it.
module des_sbox_engine #(
  parameter int LANES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [47:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_busy
);

  localparam int PASSES = 8 / LANES;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  // S1..S8, 64 nibbles each, row-major (entry = row*16 + col), S1 entry 0 at the MSB end.
  localparam logic [2047:0] SBOX_ROM = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Bit offset of an entry is 2047 - (256*box + 4*entry), i.e. the complement of {box, entry, 2'b00}.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    logic [10:0] idx;
    idx = ~{box, b[5], b[0], b[4:1], 2'b00};
    return SBOX_ROM[idx -: 4];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [47:0]      din;
  logic [31:0]      dout, dout_nxt;
  logic [5:0]       chunk [8];
  logic             last_pass;
  logic             accept;

  assign last_pass = (cnt == CNT_W'(PASSES - 1));
  assign accept    = i_valid & o_ready;
  assign o_data    = dout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = BUSY;
      BUSY:    if (last_pass) state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = i_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE) | ((state == DONE) & i_ready);
    o_valid = (state == DONE);
    o_busy  = (state == BUSY);
  end

  // Lane datapath: each lane picks its box from the pass counter; other nibbles of dout hold.
  always_comb begin
    for (int k = 0; k < 8; k++) chunk[k] = din[47-6*k -: 6];
  end

  always_comb begin
    logic [2:0] box;
    logic [3:0] nib;
    dout_nxt = dout;
    box      = '0;
    nib      = '0;
    for (int l = 0; l < LANES; l++) begin
      box = 3'(int'(cnt) * LANES + l);
      nib = sbox_lookup(box, chunk[box]);
      for (int k = 0; k < 8; k++) begin
        if (box == 3'(k)) dout_nxt[31-4*k -: 4] = nib;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt  <= '0;
      din  <= '0;
      dout <= '0;
    end else if (accept) begin
      din <= i_data;
      cnt <= '0;
    end else if (state == BUSY) begin
      dout <= dout_nxt;
      cnt  <= last_pass ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Directed bench for des_sbox_engine: one instance per legal LANES value, hand-computed S-layer vectors,
// latency/handshake timing, back-to-back streaming, DONE stall and mid-BUSY reset abort.
module tb_des_sbox_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]       vld, rdy, ordy, ovld, obusy;
  logic [3:0][47:0] dat;
  logic [3:0][31:0] odat;

  int n_chk  = 0;
  int n_pass = 0;

  logic [47:0] vin  [7];
  logic [31:0] vexp [7];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_engine #(.LANES(1 << g)) u_dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_valid(vld[g]),
      .o_ready(ordy[g]),
      .i_data (dat[g]),
      .o_valid(ovld[g]),
      .i_ready(rdy[g]),
      .o_data (odat[g]),
      .o_busy (obusy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // One word through instance g with the consumer stalled until DONE is observed.
  task automatic xfer(input int g, input logic [47:0] d, input logic [31:0] exp);
    string t;
    t = $sformatf("L%0d_%h", 1 << g, d);
    @(negedge clk);
    vld[g] = 1'b1; dat[g] = d; rdy[g] = 1'b0;
    #1 chk({t, "_ready_idle"}, ordy[g], 1);
    @(posedge clk);
    #1 vld[g] = 1'b0;
    for (int c = 0; c < (8 >> g); c++) begin
      chk($sformatf("%s_busy%0d", t, c), obusy[g], 1);
      chk($sformatf("%s_novalid%0d", t, c), {ovld[g], ordy[g]}, 2'b00);
      @(posedge clk);
      #1;
    end
    chk({t, "_valid"}, ovld[g], 1);
    chk({t, "_data"}, odat[g], exp);
    chk({t, "_done_flags"}, {obusy[g], ordy[g]}, 2'b00);
    @(negedge clk);
    rdy[g] = 1'b1;
    #1 chk({t, "_ready_comb"}, ordy[g], 1);
    @(posedge clk);
    #1 rdy[g] = 1'b0;
    chk({t, "_idle_after"}, {ovld[g], ordy[g]}, 2'b01);
  endtask

  initial begin
    int          got;
    int          tv   [2];
    logic [31:0] dv   [2];
    bit          cleared;
    bit          seen;

    vin[0] = 48'h000000000000; vexp[0] = 32'hEFA72C4D;
    vin[1] = 48'hFFFFFFFFFFFF; vexp[1] = 32'hD9CE3DCB;
    vin[2] = 48'h041041041041; vexp[2] = 32'h03DDEAD1;
    vin[3] = 48'h820820820820; vexp[3] = 32'h40DA4917;
    vin[4] = 48'h79E79E79E79E; vexp[4] = 32'h7A8F9B17;
    vin[5] = 48'hFC0000000000; vexp[5] = 32'hDFA72C4D;
    vin[6] = 48'h00000000003F; vexp[6] = 32'hEFA72C4B;

    rst = 1'b1; vld = '0; rdy = '0; dat = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++)
      chk($sformatf("L%0d_reset_outs", 1 << g), {ovld[g], obusy[g], odat[g]}, 34'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) chk($sformatf("L%0d_reset_ready", 1 << g), ordy[g], 1);

    for (int g = 3; g >= 0; g--)
      for (int v = 0; v < 7; v++) xfer(g, vin[v], vexp[v]);

    // Back-to-back on LANES=2: second word accepted in the first word's DONE cycle.
    got = 0; cleared = 1'b0; tv[0] = 0; tv[1] = 0; dv[0] = '0; dv[1] = '0;
    @(negedge clk);
    vld[1] = 1'b1; dat[1] = 48'h0; rdy[1] = 1'b1;
    @(posedge clk);
    #1 dat[1] = 48'hFFFFFFFFFFFF;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (got == 1 && !cleared) begin
        vld[1] = 1'b0;
        cleared = 1'b1;
      end
      if (ovld[1]) begin
        if (got < 2) begin
          tv[got] = c;
          dv[got] = odat[1];
        end
        got++;
      end
    end
    rdy[1] = 1'b0;
    chk("b2b_word_count", got, 2);
    chk("b2b_first", dv[0], 32'hEFA72C4D);
    chk("b2b_second", dv[1], 32'hD9CE3DCB);
    chk("b2b_first_latency", tv[0], 4);
    chk("b2b_spacing", tv[1] - tv[0], 5);

    // DONE stall on LANES=4: output frozen for 10 cycles, then exactly one transfer.
    @(negedge clk);
    vld[2] = 1'b1; dat[2] = 48'h041041041041; rdy[2] = 1'b0;
    @(posedge clk);
    #1 vld[2] = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("stall_hold%0d", c), {ovld[2], ordy[2], odat[2]}, {2'b10, 32'h03DDEAD1});
      @(posedge clk);
    end
    @(negedge clk);
    rdy[2] = 1'b1;
    #1 chk("stall_release_ready", ordy[2], 1);
    @(posedge clk);
    #1 chk("stall_single_xfer", ovld[2], 0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (ovld[2]) seen = 1'b1;
    end
    rdy[2] = 1'b0;
    chk("stall_no_dup", seen, 0);

    // Reset during the third BUSY cycle on LANES=1 drops the word.
    @(negedge clk);
    vld[0] = 1'b1; dat[0] = 48'hFFFFFFFFFFFF; rdy[0] = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort_outs", {ovld[0], obusy[0], odat[0]}, 34'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready", ordy[0], 1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 if (ovld[0]) seen = 1'b1;
    end
    chk("abort_no_emit", seen, 0);
    chk("abort_data_zero", odat[0], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
